// File: rtl/pipe_stage_pkg.sv
// pipe_stage_pkg: shared state encoding and occupancy constants for pipe_stage_buf.
package pipe_stage_pkg;
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_BUSY  = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;
endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// sat_counter: W-bit up counter with enable and synchronous clear, saturating at all-ones.
//   i_clk  clock
//   i_clr  synchronous clear (wins over i_en)
//   i_en   count enable
//   o_cnt  current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge i_clk) begin
        if (i_clr) r_cnt <= '0;
        else if (i_en && r_cnt != '1) r_cnt <= r_cnt + W'(1);
    end
    assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline stage register with squash, optional skid entry and stall counter.
//   Build option: define PIPE_SKID_EN for two-entry storage with a registered in_ready.
//   CLK/RST            clock, synchronous active-high reset
//   flush              squash held entries and any concurrent input
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and oldest payload
//   occ                entries held (0..2)
//   stall_cnt          saturating count of cycles with out_valid & ~out_ready
module pipe_stage_buf
    import pipe_stage_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occ,
    output logic [CNT_W-1:0] stall_cnt
);
    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] w_main_d;
    logic             w_load_main;
    logic             w_accept;
    logic             w_fire;

    assign out_valid = r_state != EMPTY;
    assign out_data  = r_main;
    assign occ       = (r_state == FULL) ? OCC_FULL : (r_state == BUSY) ? OCC_BUSY : OCC_EMPTY;
    assign w_accept  = in_valid & in_ready;
    assign w_fire    = out_valid & out_ready;

    always_comb begin
        w_next = r_state;
        if (flush) w_next = EMPTY;
        else case (r_state)
            EMPTY:   w_next = w_accept ? BUSY : EMPTY;
            BUSY:    w_next = (w_accept & ~w_fire) ? FULL : (~w_accept & w_fire) ? EMPTY : BUSY;
            FULL:    w_next = w_fire ? BUSY : FULL;
            default: w_next = EMPTY;
        endcase
    end

`ifdef PIPE_SKID_EN
    logic [WIDTH-1:0] r_skid;
    logic             r_in_ready;
    // FULL drains the skid entry into main; otherwise main takes fresh input
    // when it is empty or being consumed this cycle.
    assign w_main_d    = (r_state == FULL) ? r_skid : in_data;
    assign w_load_main = ~flush & ((r_state == FULL) ? w_fire : w_accept & (r_state == EMPTY | w_fire));
    assign in_ready    = r_in_ready;
    always_ff @(posedge CLK) begin
        if (~flush & w_accept & ~w_fire & (r_state == BUSY)) r_skid <= in_data;
        // ready is precomputed from the next state so it never depends on out_ready combinationally
        r_in_ready <= RST ? 1'b1 : (w_next != FULL);
    end
`else
    assign w_main_d    = in_data;
    assign w_load_main = ~flush & w_accept;
    assign in_ready    = ~out_valid | out_ready;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= EMPTY;
            r_main  <= '0;
        end else begin
            r_state <= w_next;
            if (w_load_main) r_main <= w_main_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall (
        .i_clk (CLK),
        .i_clr (RST),
        .i_en  (out_valid & ~out_ready),
        .o_cnt (stall_cnt)
    );
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed steps with a FIFO scoreboard checking pipe_stage_buf in either build.
module tb_pipe_stage_buf;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  occ;
    logic [3:0]  stall_cnt;
    int          n_err = 0;
    int          n_chk = 0;
    logic [15:0] q[$];

    pipe_stage_buf #(.WIDTH(16), .CNT_W(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occ       (occ),
        .stall_cnt (stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard: handshakes are judged at the falling edge, where everything is settled.
    always @(negedge CLK) begin
        logic [31:0] e;
        if (RST) q.delete();
        else begin
            if (out_valid && out_ready) begin
                e = (q.size() != 0) ? 32'(q.pop_front()) : 'x;
                chk("sb_data", 32'(out_data), e);
            end
            if (flush) q.delete();
            else if (in_valid && in_ready) q.push_back(in_data);
        end
    end

    initial begin
        RST = 1'b1;
        cyc;
        cyc;
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_od", 32'(out_data), 0);
        chk("rst_occ", 32'(occ), 0);
        chk("rst_stall", 32'(stall_cnt), 0);
        chk("rst_ir", 32'(in_ready), 1);
        RST = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 16'h11;
        chk("st_ir0", 32'(in_ready), 1);
        cyc;
        chk("st_ov1", 32'(out_valid), 1);
        chk("st_od1", 32'(out_data), 'h11);
        chk("st_ir1", 32'(in_ready), 1);
        in_data = 16'h22;
        cyc;
        chk("st_od2", 32'(out_data), 'h22);
        chk("st_ir2", 32'(in_ready), 1);
        in_data = 16'h33;
        cyc;
        chk("st_od3", 32'(out_data), 'h33);
        in_valid = 1'b0;
        cyc;
        chk("st_ov_end", 32'(out_valid), 0);
        chk("st_occ_end", 32'(occ), 0);
        chk("st_stall", 32'(stall_cnt), 0);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 16'hA;
        cyc;
        chk("bp_occ1", 32'(occ), 1);
        chk("bp_odA", 32'(out_data), 'hA);
`ifdef PIPE_SKID_EN
        chk("bp_ir_busy", 32'(in_ready), 1);
        in_data = 16'hB;
        cyc;
        chk("bp_occ2", 32'(occ), 2);
        chk("bp_ir_full", 32'(in_ready), 0);
        chk("bp_stall1", 32'(stall_cnt), 1);
        in_data = 16'hC;
        cyc;
        chk("bp_occ2_hold", 32'(occ), 2);
        chk("bp_odA_hold", 32'(out_data), 'hA);
        chk("bp_stall2", 32'(stall_cnt), 2);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc;
`else
        chk("bp_ir_wait", 32'(in_ready), 0);
        in_data = 16'hB;
        cyc;
        chk("bp_occ_wait", 32'(occ), 1);
        chk("bp_ir_wait2", 32'(in_ready), 0);
        chk("bp_stall1", 32'(stall_cnt), 1);
        cyc;
        chk("bp_occ_wait2", 32'(occ), 1);
        chk("bp_odA_hold", 32'(out_data), 'hA);
        chk("bp_stall2", 32'(stall_cnt), 2);
        out_ready = 1'b1;
        #1;
        chk("bp_ir_rel", 32'(in_ready), 1);
        cyc;
        in_valid = 1'b0;
`endif
        chk("bp_odB", 32'(out_data), 'hB);
        chk("bp_occB", 32'(occ), 1);
        chk("bp_stall_rel", 32'(stall_cnt), 2);
        cyc;
        chk("bp_ov_end", 32'(out_valid), 0);
        chk("bp_stall_end", 32'(stall_cnt), 2);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 16'hD;
        cyc;
`ifdef PIPE_SKID_EN
        in_data = 16'hE;
        cyc;
        chk("fl_pre_occ", 32'(occ), 2);
`else
        in_valid = 1'b0;
        cyc;
        chk("fl_pre_occ", 32'(occ), 1);
`endif
        chk("fl_pre_stall", 32'(stall_cnt), 3);
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = 16'hC;
        cyc;
        chk("fl_ov", 32'(out_valid), 0);
        chk("fl_occ", 32'(occ), 0);
        chk("fl_ir", 32'(in_ready), 1);
        chk("fl_stall", 32'(stall_cnt), 4);
        flush = 1'b0;
        in_valid = 1'b0;
        cyc;
        chk("fl_ov2", 32'(out_valid), 0);
        chk("fl_od_kept", 32'(out_data), 'hD);
        chk("fl_stall2", 32'(stall_cnt), 4);
        in_valid = 1'b1;
        in_data = 16'h55;
        cyc;
        in_valid = 1'b0;
        repeat (20) cyc;
        chk("sat_cnt", 32'(stall_cnt), 15);
        chk("sat_od", 32'(out_data), 'h55);
        cyc;
        chk("sat_hold", 32'(stall_cnt), 15);
        out_ready = 1'b1;
        cyc;
        chk("drain_ov", 32'(out_valid), 0);
        chk("sb_left", q.size(), 0);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 16'h77;
        cyc;
        chk("mr_ov_pre", 32'(out_valid), 1);
        RST = 1'b1;
        cyc;
        chk("mr_ov", 32'(out_valid), 0);
        chk("mr_occ", 32'(occ), 0);
        chk("mr_stall", 32'(stall_cnt), 0);
        chk("mr_od", 32'(out_data), 0);
        chk("mr_ir", 32'(in_ready), 1);
        RST = 1'b0;
        in_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised successor to the fixed-width pipeline latch used between the IF/ID/EX/MEM/WB stages. It replaces the global enable with a per-stage valid/ready handshake, so a stall is local backpressure rather than a freeze of every latch. It also provides a synchronous squash, an optional two-entry skid buffer for full throughput with a registered ready, and a saturating stall counter for performance debug. One instance sits at each stage boundary of the datapath, with the stage's packed struct carried on the data bus.

## Interface
Parameters:
- WIDTH, 64: payload width in bits (the packed stage struct).
- CNT_W, 16: stall counter width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- flush  in  1  squash all held entries and any concurrent input.
- in_valid  in  1  upstream stage offers in_data.
- in_ready  out  1  this block accepts in_data this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data holds a valid entry.
- out_ready  in  1  downstream consumes out_data this cycle.
- out_data  out  WIDTH  oldest held payload.
- occ  out  2  entries held (0..2; never exceeds 1 without PIPE_SKID_EN).
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid & ~out_ready.

## Operation
- Accept event: in_valid & in_ready. Fire event: out_valid & out_ready. Order is strictly FIFO.
- States: EMPTY (occ=0), BUSY (main register valid, occ=1), FULL (main and skid registers valid, occ=2; reachable only with PIPE_SKID_EN).
- EMPTY: accept -> BUSY, main <= in_data.
- BUSY, accept & fire -> BUSY, main <= in_data.
- BUSY, accept & ~fire -> FULL, skid <= in_data (skid build only; the non-skid build cannot accept here, see Configuration).
- BUSY, ~accept & fire -> EMPTY.
- FULL: in_ready=0. On fire -> BUSY, main <= skid.
- flush: next state EMPTY regardless of current state, handshake or out_ready. A concurrent accept is discarded. A concurrent fire still counts as consumed downstream. Data registers are not cleared.
- Priority: RST > flush > handshake.
- out_data always equals the main register; it holds its last value while out_valid=0.
- stall_cnt: +1 per cycle with out_valid & ~out_ready. It saturates at 2^CNT_W-1 and does not wrap. It is not cleared by flush.

## Timing
- Reset values: out_valid=0, out_data=0, occ=0, stall_cnt=0, state EMPTY. in_ready=1 in the skid build. In the non-skid build in_ready=1 after reset because out_valid=0.
- Latency: data accepted in cycle N is presented on out_data with out_valid=1 in cycle N+1 when the block was EMPTY or fired in cycle N.
- Throughput: one transfer per cycle in both builds while out_ready=1.
- out_valid, once high, stays high with out_data stable until a fire or a flush.
- flush asserted in cycle N: out_valid=0 and occ=0 in cycle N+1. in_ready is high in cycle N+1.
- RST asserted mid-transfer drops all entries in the next cycle, identical to flush, and also clears stall_cnt and out_data.

## Configuration
- PIPE_SKID_EN defined: two-entry storage. in_ready = (state != FULL) is a pure register output, with no combinational path from out_ready to in_ready.
- PIPE_SKID_EN undefined: single entry. in_ready = ~out_valid | out_ready (combinational pass-through). FULL is unreachable and occ is at most 1.
- Ports and latency are identical in both builds.

## Structure
- The shared package pipe_stage_pkg holds:
  - the state enum typedef (EMPTY, BUSY, FULL);
  - the occupancy constants.
- The stage payload structs stay in the existing pipeline register package.
- One sub-module, sat_counter (CNT_W-bit, enable plus synchronous clear, saturating), implements stall_cnt.
- Storage registers and the FSM are inline.

## Test plan
- Reset: hold RST 2 cycles -> out_valid=0, out_data=0, occ=0, stall_cnt=0, in_ready=1.
- Streaming: out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on cycles N+1..N+3, in_ready never low.
- Backpressure (skid build): out_ready=0, push 0xA then 0xB -> occ=2, in_ready=0, a third push is ignored. Release out_ready -> 0xA then 0xB delivered in order, stall_cnt counts the stall cycles exactly.
- Backpressure (non-skid build): the same stimulus -> in_ready=0 while 0xA waits and out_ready=0, 0xB is accepted on the release cycle, and occ never reaches 2.
- Flush with simultaneous push: FULL state, flush=1 and in_valid=1 with data 0xC -> next cycle out_valid=0, occ=0, and 0xC never appears. stall_cnt is unchanged by the flush.
- Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and stays there.
